// File: rtl/seg_scan_pkg.sv
// Shared constants and the hex font for the seven-segment scan driver.
package seg_scan_pkg;

    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam int unsigned SEG_DP    = 7;
    localparam int unsigned SEG_A     = 0;
    localparam int unsigned SEG_G     = 6;

    // Active-low font, bit 6..0 = g..a; the dp bit of the table is always off.
    function automatic logic [6:0] hex_font(input logic [3:0] hex);
        logic [7:0] f;
        case (hex)
            4'h0: f = 8'hC0;
            4'h1: f = 8'hF9;
            4'h2: f = 8'hA4;
            4'h3: f = 8'hB0;
            4'h4: f = 8'h99;
            4'h5: f = 8'h92;
            4'h6: f = 8'h82;
            4'h7: f = 8'hF8;
            4'h8: f = 8'h80;
            4'h9: f = 8'h90;
            4'hA: f = 8'hA0;
            4'hB: f = 8'h83;
            4'hC: f = 8'hC6;
            4'hD: f = 8'hA1;
            4'hE: f = 8'h86;
            default: f = 8'h8E;
        endcase
        return f[SEG_G:SEG_A];
    endfunction

endpackage

// File: rtl/seg_scan_segcom.sv
// Existing 4-bit hex to active-low seven-segment decoder (no dp).
module segcom
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    assign seg_c = hex_font(hex);

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed N-digit common-anode display driver with frame-synchronous
// input latching, per-digit dp/blanking and leading-zero suppression.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0]      PRE_GRD  = PRE_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      sh_value;
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blank;
    logic                  sh_lz;

    logic                  tick_c;
    logic                  frame_end_c;
    logic                  guard_c;
    logic [NUM_DIGITS-1:0] sup_c;
    logic                  zero_run_c;
    logic [3:0]            nib_c;
    logic                  dp_c;
    logic                  dark_c;
    logic [NUM_DIGITS-1:0] an_sel_c;
    logic [6:0]            font_c;

    assign tick_c      = (presc == PRE_LAST);
    assign frame_end_c = tick_c && (idx == IDX_LAST);
    assign guard_c     = (presc < PRE_GRD);

    // A digit is suppressed when it and every higher nibble are zero; digit 0 never is.
    always_comb begin
        zero_run_c = 1'b1;
        sup_c      = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run_c = zero_run_c & (sh_value[4*i +: 4] == 4'h0);
            sup_c[i]   = sh_lz & zero_run_c;
        end
    end

    // Select the nibble and attributes of the digit owning the current slot.
    always_comb begin
        nib_c    = 4'h0;
        dp_c     = 1'b0;
        dark_c   = 1'b1;
        an_sel_c = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_c       = sh_value[4*i +: 4];
                dp_c        = sh_dp[i];
                dark_c      = sh_blank[i] | sup_c[i];
                an_sel_c[i] = 1'b0;
            end
        end
    end

    segcom u_segcom (
        .hex   (nib_c),
        .seg_c (font_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            sh_lz      <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            presc <= tick_c ? '0 : presc + PRE_W'(1);
            if (tick_c) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            if (frame_end_c) begin
                sh_value <= value;
                sh_dp    <= dp_mask;
                sh_blank <= blank_mask;
                sh_lz    <= lz_en;
            end
            frame_done <= frame_end_c;
            if (guard_c || dark_c) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end else begin
                an  <= an_sel_c;
                seg <= {~dp_c, font_c};
            end
        end
    end

endmodule
